// File: rtl/bfp_decomp_exp_pkg.sv
// Shared constants, sideband payload and field-offset helper for the BFP exponent/shift codec.
package bfp_decomp_exp_pkg;

    localparam int unsigned RB_WORDS = 6;
    localparam int unsigned HDR_BITS = 8;
    localparam int unsigned EXP_MSB  = 59;
    localparam int unsigned EXP_LSB  = 56;
    localparam int unsigned LANES    = 4;
    localparam int unsigned SAMPLE_W = 16;
    localparam int unsigned WORD_W   = 64;
    localparam int unsigned EXP_W    = 4;
    localparam int unsigned WID_W    = 4;
    localparam int unsigned ST_W     = 3;
    localparam int unsigned OFF_W    = 6;

    typedef struct packed {
        logic            valid;
        logic            sync;
        logic            last;
        logic [ST_W-1:0] st;
        logic            err;
    } side_t;

    // Bit distance from the word MSB to the MSB of a lane's mantissa field.
    function automatic logic [OFF_W-1:0] get_field_offset(
        input logic [1:0]       lane,
        input logic [WID_W-1:0] w,
        input logic             first
    );
        return (first ? OFF_W'(HDR_BITS) : OFF_W'(0)) + OFF_W'(lane) * OFF_W'(w);
    endfunction

endpackage

// File: rtl/bfp_decomp_exp_if.sv
// Compressed-in / expanded-out word stream between the decompressor and its neighbours.
interface bfp_decomp_exp_if;
    import bfp_decomp_exp_pkg::*;

    logic [WORD_W-1:0] din_data;
    logic              din_valid;
    logic              din_sync;
    logic              din_last;
    logic [WORD_W-1:0] dout_data;
    logic [ST_W-1:0]   dout_state;
    logic              dout_valid;
    logic              dout_sync;
    logic              dout_last;
    logic              dout_err;

    modport master (
        output din_data, din_valid, din_sync, din_last,
        input  dout_data, dout_state, dout_valid, dout_sync, dout_last, dout_err
    );

    modport slave (
        input  din_data, din_valid, din_sync, din_last,
        output dout_data, dout_state, dout_valid, dout_sync, dout_last, dout_err
    );

endinterface

// File: rtl/bfp_decomp_exp_lane.sv
// One sample lane: extract the MSB-aligned mantissa field, then sign-extend and scale by 2^e.
module bfp_decomp_exp_lane
    import bfp_decomp_exp_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [WORD_W-1:0]   i_word,
    input  logic [1:0]          i_lane,
    input  logic [WID_W-1:0]    i_w,
    input  logic [EXP_W-1:0]    i_e,
    input  logic                i_first,
    output logic [SAMPLE_W-1:0] o_sample
);

    logic [OFF_W-1:0]    w_off;
    logic [SAMPLE_W-1:0] w_top;
    logic [SAMPLE_W-1:0] w_mask;
    logic [4:0]          w_rsh;

    logic [SAMPLE_W-1:0] r_mant;
    logic [4:0]          r_rsh;
    logic                r_zero;
    logic [SAMPLE_W-1:0] r_sample;

    assign w_off  = get_field_offset(i_lane, i_w, i_first);
    assign w_top  = SAMPLE_W'((i_word << w_off) >> (WORD_W - SAMPLE_W));
    assign w_mask = {SAMPLE_W{1'b1}} << (5'(SAMPLE_W) - 5'(i_w));
    // sext(m) << e == (m aligned to bit 15) >>> (16 - w - e), with e <= 16 - w
    assign w_rsh  = 5'(SAMPLE_W) - 5'(i_w) - 5'(i_e);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mant   <= '0;
            r_rsh    <= '0;
            r_zero   <= 1'b0;
            r_sample <= '0;
        end else begin
            r_mant   <= w_top & w_mask;
            r_rsh    <= w_rsh;
            r_zero   <= (i_w == '0) || (i_w == '1);
            r_sample <= r_zero ? '0 : SAMPLE_W'($signed(r_mant) >>> r_rsh);
        end
    end

    assign o_sample = r_sample;

endmodule

// File: rtl/bfp_decomp_exp.sv
// Block-floating-point decompressor: per-RB exponent hold, clamp, 4-lane expand, 3-cycle sideband delay.
module bfp_decomp_exp
    import bfp_decomp_exp_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [WID_W-1:0] ud_iq_width,
    bfp_decomp_exp_if.slave  bus
);

    logic [ST_W-1:0]     r_st;
    logic [EXP_W-1:0]    r_exp_hold;
    logic [WID_W-1:0]    r_w_hold;
    logic                w_first;
    logic                w_take;
    logic [EXP_W-1:0]    w_exp_cur;
    logic [WID_W-1:0]    w_w_cur;

    logic [WORD_W-1:0]   r1_data;
    logic [EXP_W-1:0]    r1_exp;
    logic [WID_W-1:0]    r1_w;
    side_t               r1_side;
    side_t               r2_side;
    side_t               r3_side;

    logic [4:0]          w_lim;
    logic                w_w_ok;
    logic                w_clamp;
    logic [EXP_W-1:0]    w_e;
    logic                w_err;
    logic [SAMPLE_W-1:0] w_sample [LANES];

    assign w_first   = (r_st == '0);
    assign w_take    = bus.din_valid && w_first;
    assign w_exp_cur = w_take ? bus.din_data[EXP_MSB:EXP_LSB] : r_exp_hold;
    assign w_w_cur   = w_take ? ud_iq_width : r_w_hold;

    // Word counter and per-RB exponent/width hold; invalid cycles leave both untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_st       <= '0;
            r_exp_hold <= '0;
            r_w_hold   <= '0;
        end else if (bus.din_valid) begin
            r_exp_hold <= w_exp_cur;
            r_w_hold   <= w_w_cur;
            if (bus.din_last || (r_st == ST_W'(RB_WORDS - 1))) begin
                r_st <= '0;
            end else begin
                r_st <= r_st + ST_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r1_data <= '0;
            r1_exp  <= '0;
            r1_w    <= '0;
            r1_side <= '0;
            r2_side <= '0;
            r3_side <= '0;
        end else begin
            r1_data <= bus.din_data;
            r1_exp  <= w_exp_cur;
            r1_w    <= w_w_cur;
            r1_side <= '{valid: bus.din_valid, sync: bus.din_sync, last: bus.din_last,
                         st: r_st, err: 1'b0};
            r2_side <= '{valid: r1_side.valid, sync: r1_side.sync, last: r1_side.last,
                         st: r1_side.st, err: w_err};
            r3_side <= r2_side;
        end
    end

    // Largest shift that keeps the top mantissa bit inside 16 bits is 16 - w.
    assign w_lim   = 5'(SAMPLE_W) - 5'(r1_w);
    assign w_w_ok  = (r1_w != '0) && (r1_w != '1);
    assign w_clamp = 5'(r1_exp) > w_lim;
    assign w_e     = w_clamp ? w_lim[EXP_W-1:0] : r1_exp;
    assign w_err   = r1_side.valid && (r1_side.st == '0) && w_w_ok && w_clamp;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        bfp_decomp_exp_lane u_lane (
            .clk      (clk),
            .rst      (rst),
            .i_word   (r1_data),
            .i_lane   (2'(i)),
            .i_w      (r1_w),
            .i_e      (w_e),
            .i_first  (r1_side.st == '0),
            .o_sample (w_sample[i])
        );
    end

    assign bus.dout_data  = {w_sample[0], w_sample[1], w_sample[2], w_sample[3]};
    assign bus.dout_state = r3_side.st;
    assign bus.dout_valid = r3_side.valid;
    assign bus.dout_sync  = r3_side.sync;
    assign bus.dout_last  = r3_side.last;
    assign bus.dout_err   = r3_side.err;

endmodule

// File: tb/tb_bfp_decomp_exp.sv
// Scoreboard bench for bfp_decomp_exp: directed RB vectors plus a small random RB sweep.
module tb_bfp_decomp_exp;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] ud  = 4'd0;

    bfp_decomp_exp_if bus ();

    bfp_decomp_exp dut (
        .clk         (clk),
        .rst         (rst),
        .ud_iq_width (ud),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] data;
        logic [2:0]  st;
        logic        sync;
        logic        last;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    bit   done   = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s act=%h req=%h t=%0t", nm, act, req, $time);
    endtask

    // Monitor: reset-state checks, then pop-and-compare on every valid output word.
    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            chk("drain_queue_empty", 64'(q.size()), 64'd0);
            $display("%0d/%0d checks passed", n_pass, n_chk);
            $finish;
        end else if (cyc > 20000) begin
            n_chk++;
            $display("FAIL timeout cyc=%0d pending=%0d", cyc, q.size());
            $display("%0d/%0d checks passed", n_pass, n_chk);
            $finish;
        end else if (rst) begin
            chk("rst_data",  bus.dout_data, 64'd0);
            chk("rst_state", 64'(bus.dout_state), 64'd0);
            chk("rst_valid", 64'(bus.dout_valid), 64'd0);
            chk("rst_side",  64'({bus.dout_sync, bus.dout_last, bus.dout_err}), 64'd0);
        end else if (bus.dout_valid) begin
            if (q.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_valid act=%h req=none t=%0t", bus.dout_data, $time);
            end else begin
                e = q.pop_front();
                chk("data",    bus.dout_data, e.data);
                chk("state",   64'(bus.dout_state), 64'(e.st));
                chk("sync",    64'(bus.dout_sync), 64'(e.sync));
                chk("last",    64'(bus.dout_last), 64'(e.last));
                chk("err",     64'(bus.dout_err), 64'(e.err));
                chk("latency", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    function automatic logic [63:0] pack(input int w, input logic [3:0] ex, input bit first,
                                         input logic [13:0] m0, m1, m2, m3);
        logic [63:0] d;
        logic [13:0] m [4];
        int base;
        d = '0;
        m = '{m0, m1, m2, m3};
        base = first ? 55 : 63;
        if (first) d[59:56] = ex;
        for (int i = 0; i < 4; i++)
            for (int b = 0; b < w; b++)
                d[base - i*w - b] = m[i][w-1-b];
        return d;
    endfunction

    function automatic logic [15:0] exp_sample(input int w, input int ex, input logic [13:0] m);
        int v, e;
        if (w == 0 || w == 15) return 16'd0;
        v = int'(m) & ((1 << w) - 1);
        if (v >= (1 << (w - 1))) v -= (1 << w);
        e = (ex > 16 - w) ? 16 - w : ex;
        return 16'(v * (1 << e));
    endfunction

    task automatic send(input logic [63:0] d, input logic [3:0] w, input logic s, input logic l,
                        input logic [2:0] st, input logic er,
                        input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] c, input logic [15:0] dd);
        exp_t e;
        @(posedge clk); #1;
        bus.din_data  = d;
        bus.din_valid = 1'b1;
        bus.din_sync  = s;
        bus.din_last  = l;
        ud            = w;
        e = '{data: {a, b, c, dd}, st: st, sync: s, last: l, err: er, cyc: cyc + 3};
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            bus.din_data  = {$urandom, $urandom};
            bus.din_valid = 1'b0;
            bus.din_sync  = 1'b0;
            bus.din_last  = 1'b0;
        end
    endtask

    initial begin
        logic [63:0] rnd;
        bus.din_data  = '0;
        bus.din_valid = 1'b0;
        bus.din_sync  = 1'b0;
        bus.din_last  = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // w=9 exp=3 word 0, then words 1..5 of -256 with a mid-RB width change and a gap
        send(pack(9, 4'd3, 1, 9'h0FF, 9'h1FF, 9'h001, 9'h100), 9, 1, 0, 3'd0, 0,
             16'h07F8, 16'hFFF8, 16'h0008, 16'hF800);
        for (int k = 1; k <= 5; k++) begin
            send(pack(9, 4'd0, 0, 9'h100, 9'h100, 9'h100, 9'h100), (k >= 3) ? 4'd4 : 4'd9,
                 0, 0, 3'(k), 0, 16'hF800, 16'hF800, 16'hF800, 16'hF800);
            if (k == 2) idle(1);
        end

        // exp=8 clamps to 7 with err; top nibble of word 0 is ignored; RB ends early on word 3
        send(pack(9, 4'd8, 1, 9'h001, 9'h001, 9'h001, 9'h001) | 64'hF000_0000_0000_0000, 9,
             0, 0, 3'd0, 1, 16'h0080, 16'h0080, 16'h0080, 16'h0080);
        send(pack(9, 4'd0, 0, 9'h001, 9'h001, 9'h001, 9'h001), 9, 0, 0, 3'd1, 0,
             16'h0080, 16'h0080, 16'h0080, 16'h0080);
        send(pack(9, 4'd0, 0, 9'h0FF, 9'h0FF, 9'h0FF, 9'h0FF), 9, 0, 0, 3'd2, 0,
             16'h7F80, 16'h7F80, 16'h7F80, 16'h7F80);
        send(pack(9, 4'd0, 0, 9'h1FF, 9'h1FF, 9'h1FF, 9'h1FF), 9, 0, 1, 3'd3, 0,
             16'hFF80, 16'hFF80, 16'hFF80, 16'hFF80);

        // New RB after short one: w=4 exp=1
        send(pack(4, 4'd1, 1, 4'h7, 4'h8, 4'hF, 4'h1), 4, 0, 0, 3'd0, 0,
             16'h000E, 16'hFFF0, 16'hFFFE, 16'h0002);
        idle(2);
        send(pack(4, 4'd0, 0, 4'h0, 4'h3, 4'h0, 4'h0), 4, 0, 1, 3'd1, 0,
             16'h0000, 16'h0006, 16'h0000, 16'h0000);

        // Unsupported widths 0 and 15 zero the data but keep the sideband
        rnd = {$urandom, $urandom};
        send(rnd | 64'h0F00_0000_0000_0000, 0, 1, 0, 3'd0, 0, 16'h0, 16'h0, 16'h0, 16'h0);
        rnd = {$urandom, $urandom};
        send(rnd, 0, 0, 1, 3'd1, 0, 16'h0, 16'h0, 16'h0, 16'h0);
        rnd = {$urandom, $urandom};
        send(rnd | 64'h0F00_0000_0000_0000, 15, 1, 0, 3'd0, 0, 16'h0, 16'h0, 16'h0, 16'h0);
        for (int k = 1; k <= 5; k++) begin
            rnd = {$urandom, $urandom};
            send(rnd, 15, (k == 2), 0, 3'(k), 0, 16'h0, 16'h0, 16'h0, 16'h0);
        end
        idle(2);

        // Reset mid-RB (counter at 2) after gapped words; next RB must decode as word 0
        send(pack(6, 4'd2, 1, 6'h01, 6'h02, 6'h03, 6'h04), 6, 0, 0, 3'd0, 0,
             16'h0004, 16'h0008, 16'h000C, 16'h0010);
        idle(1);
        send(pack(6, 4'd0, 0, 6'h3F, 6'h3F, 6'h3F, 6'h3F), 6, 0, 0, 3'd1, 0,
             16'hFFFC, 16'hFFFC, 16'hFFFC, 16'hFFFC);
        idle(6);
        @(posedge clk); #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        send(pack(6, 4'd4, 1, 6'h3F, 6'h1F, 6'h20, 6'h01), 6, 0, 0, 3'd0, 0,
             16'hFFF0, 16'h01F0, 16'hFE00, 16'h0010);
        send(pack(6, 4'd0, 0, 6'h02, 6'h02, 6'h02, 6'h02), 6, 0, 1, 3'd1, 0,
             16'h0020, 16'h0020, 16'h0020, 16'h0020);

        // Width extremes: w=14 clamps exp 5 to 2; w=1 with exp 15 is exactly at the limit
        send(pack(14, 4'd5, 1, 14'h2000, 14'h1FFF, 14'h0001, 14'h0000), 14, 0, 0, 3'd0, 1,
             16'h8000, 16'h7FFC, 16'h0004, 16'h0000);
        send(pack(14, 4'd0, 0, 14'h3FFF, 14'h3FFF, 14'h3FFF, 14'h3FFF), 14, 0, 1, 3'd1, 0,
             16'hFFFC, 16'hFFFC, 16'hFFFC, 16'hFFFC);
        send(pack(1, 4'd15, 1, 14'h1, 14'h0, 14'h1, 14'h0), 1, 0, 1, 3'd0, 0,
             16'h8000, 16'h0000, 16'h8000, 16'h0000);

        // Random full RBs against the sign-extend-and-scale model
        for (int r = 0; r < 6; r++) begin
            int w, ex;
            logic [13:0] m0, m1, m2, m3;
            w  = $urandom_range(1, 14);
            ex = $urandom_range(0, 15);
            for (int k = 0; k < 6; k++) begin
                m0 = 14'($urandom) & 14'((1 << w) - 1);
                m1 = 14'($urandom) & 14'((1 << w) - 1);
                m2 = 14'($urandom) & 14'((1 << w) - 1);
                m3 = 14'($urandom) & 14'((1 << w) - 1);
                send(pack(w, 4'(ex), (k == 0), m0, m1, m2, m3), 4'(w), 0, 0, 3'(k),
                     (k == 0) && (ex > 16 - w),
                     exp_sample(w, ex, m0), exp_sample(w, ex, m1),
                     exp_sample(w, ex, m2), exp_sample(w, ex, m3));
            end
            if (r == 2) idle(1);
        end

        idle(1);
        for (int i = 0; i < 20 && q.size() != 0; i++) idle(1);
        done = 1'b1;
    end

endmodule
